vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//  Parametrised VGA timing and test-pattern source, replacing the fixed turquoise-ramp bench logic.
//  Generates h/v sync, DE and RGB from its own counters, so the DAC/DVI pads can be driven without CRTC or sequencer.
//  Selects one of six patterns at run time; selection changes only on frame boundaries.
//  Outputs are registered for IOB packing; the board drives vgaclk = ~clock_i.
// PARAMETERS
//  HDISP      640  active pixels per line (multiple of 8)
//  HFP        16   horizontal front porch, pixels
//  HSYNC      96   hsync width, pixels
//  HBP        48   horizontal back porch, pixels
//  VDISP      480  active lines
//  VFP        10   vertical front porch, lines
//  VSYNC      2    vsync width, lines
//  VBP        33   vertical back porch, lines
//  CW         8    bits per colour channel (>=1, <=HW-1)
//  HPOL       0    hsync active level
//  VPOL       0    vsync active level
//  Derived: HTOTAL=HDISP+HFP+HSYNC+HBP, VTOTAL likewise; HW=clog2(HTOTAL), VW=clog2(VTOTAL)
// PORTS
//  clock_i    in   1     dot clock
//  reset_ni   in   1     async active-low reset
//  enable_i   in   1     run (tie to clock-gen locked)
//  mode_i     in   3     pattern select, sampled at frame start
//  solid_i    in   3*CW  {r,g,b} for solid mode
//  hsync_o    out  1     horizontal sync, polarity HPOL
//  vsync_o    out  1     vertical sync, polarity VPOL
//  de_o       out  1     display enable
//  red_o      out  CW    red
//  green_o    out  CW    green
//  blue_o     out  CW    blue
//  frame_o    out  1     1-cycle pulse, first pixel of each frame
// BEHAVIOUR
//  Reset: hcnt=vcnt=0, mode_q=0, fcnt=0, de_o=0, rgb=0, frame_o=0, hsync_o=~HPOL, vsync_o=~VPOL.
//  enable_i=0: counters forced to 0, outputs held at reset values next cycle. On rising enable_i, a frame starts at (0,0).
//  Counters: hcnt 0..HTOTAL-1 wraps and increments vcnt; vcnt wraps at VTOTAL-1. Wrap to (0,0) = frame start.
//  Active when hcnt<HDISP && vcnt<VDISP. hsync active for hcnt in [HDISP+HFP, HDISP+HFP+HSYNC);
//   vsync active for vcnt in [VDISP+VFP, VDISP+VFP+VSYNC), edge-aligned with hcnt==0.
//  Latency: 1 cycle; all outputs reflect the (hcnt,vcnt) of the previous cycle, mutually aligned.
//  At frame start: mode_q<=mode_i, fcnt<=fcnt+1 (HW bits, wraps to 0 at HDISP), frame_o=1 aligned with pixel (0,0).
//  Mid-frame mode_i changes are ignored until the next frame start.
//  Outside active: rgb=0 in all modes.
//  Modes (mode_q):
//   0 black
//   1 solid = solid_i
//   2 ramp: r=0, g=b=hcnt[CW:1]
//   3 colour bars: 8 bars of HDISP/8 pixels, tracked by bar counter (no divider), reset at hcnt==0;
//     order white, yellow, cyan, green, magenta, red, blue, black; full scale = all ones
//   4 checker: 8x8 cells, white when hcnt[3]^vcnt[3]^fcnt[0], else black
//   5 walking line: white where hcnt==fcnt, else blue at half scale (MSB only)
//   6,7 black
//  Simultaneous hcnt and vcnt wrap: a single frame start, with one frame_o and one fcnt increment.
//  enable_i dropped mid-line: the partial frame is discarded, mode_q is kept, fcnt is not incremented.
// STRUCTURE
//  vga_pkg: mode constants (PAT_BLACK..PAT_WALK), 8-entry colour-bar table, timing defaults.
//  Sub-module vga_timing: h/v counters, sync/active decode, frame-start strobe; parametrised as above.
//  Top: mode latch, fcnt, bar counter, pattern mux, output register stage.
// TESTING
//  Reset low 5 cycles -> hsync_o=vsync_o=1, de_o=0, rgb=0; release with enable_i=1 -> frame_o at cycle 1.
//  Defaults, run 2 frames -> 800 clocks/line, 525 lines/frame, hsync low 96 clocks from hcnt 656, vsync low 2 lines from line 490.
//  mode_i=3 -> line 0: pixel 0 rgb=FFFFFF, pixel 80 =FFFF00, pixel 639 =000000, pixel 640 de_o=0.
//  mode_i 2->1 at line 100 -> ramp continues to frame end, solid_i appears from pixel (0,0) of the next frame.
//  mode_i=5, 4 frames after enable -> white only at x=3 on every active line, other pixels b=80, r=g=0.
//  enable_i low at hcnt=300 for 10 cycles -> outputs idle within 1 cycle, restart at (0,0), fcnt unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern source: pattern codes,
// default 640x480@60 timing and the colour-bar palette.
package vga_pkg;

    typedef enum logic [2:0] {
        PAT_BLACK = 3'd0,
        PAT_SOLID = 3'd1,
        PAT_RAMP  = 3'd2,
        PAT_BARS  = 3'd3,
        PAT_CHECK = 3'd4,
        PAT_WALK  = 3'd5
    } pattern_e;

    localparam int unsigned DEF_HDISP = 640;
    localparam int unsigned DEF_HFP   = 16;
    localparam int unsigned DEF_HSYNC = 96;
    localparam int unsigned DEF_HBP   = 48;
    localparam int unsigned DEF_VDISP = 480;
    localparam int unsigned DEF_VFP   = 10;
    localparam int unsigned DEF_VSYNC = 2;
    localparam int unsigned DEF_VBP   = 33;

    // {r,g,b} on/off per bar, left to right.
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync, active-area and
// frame-start decode; counters park at (0,0) while disabled.
module vga_timing #(
    parameter int unsigned HDISP = 640,
    parameter int unsigned HFP   = 16,
    parameter int unsigned HSYNC = 96,
    parameter int unsigned HBP   = 48,
    parameter int unsigned VDISP = 480,
    parameter int unsigned VFP   = 10,
    parameter int unsigned VSYNC = 2,
    parameter int unsigned VBP   = 33,
    parameter int unsigned HW    = $clog2(HDISP + HFP + HSYNC + HBP),
    parameter int unsigned VW    = $clog2(VDISP + VFP + VSYNC + VBP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic [HW-1:0] hcnt,
    output logic          vtile,
    output logic          active,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          frame_start,
    output logic          frame_wrap,
    output logic          line_last
);

    localparam int unsigned HTOTAL = HDISP + HFP + HSYNC + HBP;
    localparam int unsigned VTOTAL = VDISP + VFP + VSYNC + VBP;

    logic [VW-1:0] vcnt;
    logic          running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt    <= '0;
            vcnt    <= '0;
            running <= 1'b0;
        end else if (!enable) begin
            hcnt    <= '0;
            vcnt    <= '0;
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            if (hcnt == HW'(HTOTAL - 1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == VW'(VTOTAL - 1)) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    always_comb begin
        vtile       = vcnt[3];
        active      = (hcnt < HW'(HDISP)) && (vcnt < VW'(VDISP));
        hsync_act   = (hcnt >= HW'(HDISP + HFP)) && (hcnt < HW'(HDISP + HFP + HSYNC));
        vsync_act   = (vcnt >= VW'(VDISP + VFP)) && (vcnt < VW'(VDISP + VFP + VSYNC));
        line_last   = (hcnt == HW'(HTOTAL - 1));
        frame_start = enable && (hcnt == '0) && (vcnt == '0);
        // Only a start reached by wrapping completes a frame; a restart does not.
        frame_wrap  = frame_start && running;
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus run-time selectable test pattern, with all outputs
// registered one cycle behind the raster counters.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned HDISP = DEF_HDISP,
    parameter int unsigned HFP   = DEF_HFP,
    parameter int unsigned HSYNC = DEF_HSYNC,
    parameter int unsigned HBP   = DEF_HBP,
    parameter int unsigned VDISP = DEF_VDISP,
    parameter int unsigned VFP   = DEF_VFP,
    parameter int unsigned VSYNC = DEF_VSYNC,
    parameter int unsigned VBP   = DEF_VBP,
    parameter int unsigned CW    = 8,
    parameter bit          HPOL  = 1'b0,
    parameter bit          VPOL  = 1'b0
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    input  logic            enable_i,
    input  logic [2:0]      mode_i,
    input  logic [3*CW-1:0] solid_i,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            de_o,
    output logic [CW-1:0]   red_o,
    output logic [CW-1:0]   green_o,
    output logic [CW-1:0]   blue_o,
    output logic            frame_o
);

    localparam int unsigned HTOTAL = HDISP + HFP + HSYNC + HBP;
    localparam int unsigned VTOTAL = VDISP + VFP + VSYNC + VBP;
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned VW     = $clog2(VTOTAL);
    localparam int unsigned BAR_W  = HDISP / 8;

    logic [HW-1:0] hcnt;
    logic          vtile, active, hsync_act, vsync_act;
    logic          frame_start, frame_wrap, line_last;

    vga_timing #(
        .HDISP(HDISP), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VDISP(VDISP), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk        (clock_i),
        .rst_n      (reset_ni),
        .enable     (enable_i),
        .hcnt       (hcnt),
        .vtile      (vtile),
        .active     (active),
        .hsync_act  (hsync_act),
        .vsync_act  (vsync_act),
        .frame_start(frame_start),
        .frame_wrap (frame_wrap),
        .line_last  (line_last)
    );

    logic [2:0]    mode_q, mode_eff;
    logic [HW-1:0] fcnt, fcnt_next, fcnt_eff;
    logic [HW-1:0] bar_px;
    logic [2:0]    bar_idx, bar_rgb;
    logic [CW-1:0] red, green, blue;

    always_comb begin
        fcnt_next = (fcnt == HW'(HDISP - 1)) ? '0 : fcnt + HW'(1);
        // Pixel (0,0) must already see the mode and count being latched this cycle.
        fcnt_eff  = frame_wrap ? fcnt_next : fcnt;
        mode_eff  = frame_start ? mode_i : mode_q;
        bar_rgb   = bar_colour(bar_idx);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mode_q <= '0;
            fcnt   <= '0;
        end else begin
            if (frame_start) mode_q <= mode_i;
            if (frame_wrap)  fcnt   <= fcnt_next;
        end
    end

    // Bar position tracked incrementally, aligned with hcnt.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (!enable_i || line_last) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (bar_px == HW'(BAR_W - 1)) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_px  <= bar_px + HW'(1);
        end
    end

    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        if (active) begin
            case (mode_eff)
                PAT_SOLID: begin
                    red   = solid_i[3*CW-1:2*CW];
                    green = solid_i[2*CW-1:CW];
                    blue  = solid_i[CW-1:0];
                end
                PAT_RAMP: begin
                    green = hcnt[CW:1];
                    blue  = hcnt[CW:1];
                end
                PAT_BARS: begin
                    red   = {CW{bar_rgb[2]}};
                    green = {CW{bar_rgb[1]}};
                    blue  = {CW{bar_rgb[0]}};
                end
                PAT_CHECK: begin
                    if (hcnt[3] ^ vtile ^ fcnt_eff[0]) begin
                        red   = '1;
                        green = '1;
                        blue  = '1;
                    end
                end
                PAT_WALK: begin
                    if (hcnt == fcnt_eff) begin
                        red   = '1;
                        green = '1;
                        blue  = '1;
                    end else begin
                        blue[CW-1] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hsync_o <= ~HPOL;
            vsync_o <= ~VPOL;
            de_o    <= 1'b0;
            frame_o <= 1'b0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else if (!enable_i) begin
            hsync_o <= ~HPOL;
            vsync_o <= ~VPOL;
            de_o    <= 1'b0;
            frame_o <= 1'b0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else begin
            hsync_o <= hsync_act ? HPOL : ~HPOL;
            vsync_o <= vsync_act ? VPOL : ~VPOL;
            de_o    <= active;
            frame_o <= frame_start;
            red_o   <= red;
            green_o <= green;
            blue_o  <= blue;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster: directed sequences, a pixel
// probe table and randomized running against a raster-position model.
module tb_vga_pattern_gen;

    localparam int HDISP = 32, HFP = 4, HSYNC = 8, HBP = 4;
    localparam int VDISP = 20, VFP = 2, VSYNC = 2, VBP = 3;
    localparam int CW    = 4;
    localparam int HT    = HDISP + HFP + HSYNC + HBP;
    localparam int VT    = VDISP + VFP + VSYNC + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW    = HDISP / 8;
    localparam int RGBW  = 3 * CW;

    logic            clock_i = 1'b0;
    logic            reset_ni, enable_i;
    logic [2:0]      mode_i;
    logic [RGBW-1:0] solid_i;
    logic            hsync_o, vsync_o, de_o, frame_o;
    logic [CW-1:0]   red_o, green_o, blue_o;
    logic [RGBW-1:0] rgb;

    assign rgb = {red_o, green_o, blue_o};

    vga_pattern_gen #(
        .HDISP(HDISP), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VDISP(VDISP), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
        .CW(CW), .HPOL(1'b0), .VPOL(1'b0)
    ) dut (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .enable_i(enable_i),
        .mode_i  (mode_i),
        .solid_i (solid_i),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .de_o    (de_o),
        .red_o   (red_o),
        .green_o (green_o),
        .blue_o  (blue_o),
        .frame_o (frame_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference pixel from raster position, pattern rules and frame count.
    function automatic int ref_rgb(int x, int y, int mode, int fcnt, int solid);
        int full, r, g, b, c;
        int bars[8];
        bars = '{7, 6, 3, 2, 5, 4, 1, 0};
        full = (1 << CW) - 1;
        r = 0; g = 0; b = 0;
        if (x >= HDISP || y >= VDISP) return 0;
        case (mode)
            1: return solid;
            2: begin g = (x / 2) % (1 << CW); b = g; end
            3: begin
                c = bars[x / BW];
                r = (c & 4) != 0 ? full : 0;
                g = (c & 2) != 0 ? full : 0;
                b = (c & 1) != 0 ? full : 0;
            end
            4: if (((x / 8) + (y / 8) + fcnt) % 2 == 1) begin r = full; g = full; b = full; end
            5: if (x == fcnt) begin r = full; g = full; b = full; end
               else b = 1 << (CW - 1);
            default: ;
        endcase
        return (r << (2 * CW)) | (g << CW) | b;
    endfunction

    bit   sb_on = 1'b0;
    bit   m_run = 1'b0;
    int   m_t, m_mode, m_fcnt, pos, px, py;
    logic [RGBW+3:0] exp_vec;

    always @(posedge clock_i) begin
        if (!reset_ni) begin
            m_run = 1'b0; m_mode = 0; m_fcnt = 0;
            exp_vec = {2'b11, 2'b00, RGBW'(0)};
        end else if (!enable_i) begin
            m_run = 1'b0;
            exp_vec = {2'b11, 2'b00, RGBW'(0)};
        end else begin
            if (!m_run) begin
                m_run = 1'b1; m_t = 0; m_mode = int'(mode_i);
            end else begin
                m_t++;
                if (m_t % FRAME == 0) begin
                    m_mode = int'(mode_i);
                    m_fcnt = (m_fcnt + 1) % HDISP;
                end
            end
            pos = m_t % FRAME; px = pos % HT; py = pos / HT;
            exp_vec = {
                !(px >= HDISP + HFP && px < HDISP + HFP + HSYNC),
                !(py >= VDISP + VFP && py < VDISP + VFP + VSYNC),
                (px < HDISP && py < VDISP),
                (pos == 0),
                RGBW'(ref_rgb(px, py, m_mode, m_fcnt, int'(solid_i)))
            };
        end
        #1;
        if (sb_on) check("scoreboard", {hsync_o, vsync_o, de_o, frame_o, rgb}, exp_vec);
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_o && n < 2 * FRAME + 2);
        if (!frame_o) check("frame_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [2:0]      mode;
        logic [RGBW-1:0] solid;
        int              x;
        int              y;
        logic            de;
        logic [RGBW-1:0] rgb;
    } vec_t;

    vec_t vecs[17];

    int n, hs_low, vs_low, first_hs, first_vs, hold;

    initial begin
        vecs[0]  = '{3'd3, 12'h000,  0,  0, 1'b1, 12'hFFF};
        vecs[1]  = '{3'd3, 12'h000,  4,  0, 1'b1, 12'hFF0};
        vecs[2]  = '{3'd3, 12'h000,  8,  0, 1'b1, 12'h0FF};
        vecs[3]  = '{3'd3, 12'h000, 12,  0, 1'b1, 12'h0F0};
        vecs[4]  = '{3'd3, 12'h000, 16,  3, 1'b1, 12'hF0F};
        vecs[5]  = '{3'd3, 12'h000, 20,  3, 1'b1, 12'hF00};
        vecs[6]  = '{3'd3, 12'h000, 27, 19, 1'b1, 12'h00F};
        vecs[7]  = '{3'd3, 12'h000, 31,  0, 1'b1, 12'h000};
        vecs[8]  = '{3'd3, 12'h000, 32,  0, 1'b0, 12'h000};
        vecs[9]  = '{3'd3, 12'h000,  0, 20, 1'b0, 12'h000};
        vecs[10] = '{3'd2, 12'h000, 10,  3, 1'b1, 12'h055};
        vecs[11] = '{3'd2, 12'h000, 31,  0, 1'b1, 12'h0FF};
        vecs[12] = '{3'd1, 12'hA5C,  5,  7, 1'b1, 12'hA5C};
        vecs[13] = '{3'd1, 12'hA5C, 40,  7, 1'b0, 12'h000};
        vecs[14] = '{3'd6, 12'hFFF,  5,  5, 1'b1, 12'h000};
        vecs[15] = '{3'd7, 12'hFFF,  5,  5, 1'b1, 12'h000};
        vecs[16] = '{3'd0, 12'hFFF,  5,  5, 1'b1, 12'h000};

        reset_ni = 1'b0; enable_i = 1'b1; mode_i = 3'd5; solid_i = '0;
        repeat (5) @(posedge clock_i);
        #1;
        check("reset_hsync", hsync_o, 1);
        check("reset_vsync", vsync_o, 1);
        check("reset_de", de_o, 0);
        check("reset_rgb", rgb, 0);
        check("reset_frame", frame_o, 0);
        @(negedge clock_i);
        reset_ni = 1'b1;
        sb_on = 1'b1;
        tick();
        check("first_frame_o", frame_o, 1);

        // Walking line: fourth frame after enable has the line at x=3.
        repeat (3) wait_frame();
        step(5 * HT + 2);
        check("walk_x2", rgb, 12'h008);
        step(1);
        check("walk_x3", rgb, 12'hFFF);
        step(1);
        check("walk_x4", rgb, 12'h008);

        // Drop enable mid-line for 10 cycles, then restart from (0,0).
        step(3 * HT + 16);
        @(negedge clock_i);
        enable_i = 1'b0;
        tick();
        check("idle_de", de_o, 0);
        check("idle_hsync", hsync_o, 1);
        check("idle_rgb", rgb, 0);
        step(9);
        @(negedge clock_i);
        enable_i = 1'b1;
        tick();
        check("restart_frame_o", frame_o, 1);
        step(HT + 3);
        check("restart_walk_x3", rgb, 12'hFFF);

        for (int i = 0; i < 17; i++) begin
            @(negedge clock_i);
            mode_i = vecs[i].mode;
            solid_i = vecs[i].solid;
            wait_frame();
            step(vecs[i].y * HT + vecs[i].x);
            check($sformatf("vec%0d_de", i), de_o, vecs[i].de);
            check($sformatf("vec%0d_rgb", i), rgb, vecs[i].rgb);
        end

        // Mid-frame mode change takes effect only at the next frame.
        @(negedge clock_i);
        mode_i = 3'd2;
        wait_frame();
        step(10 * HT + 10);
        @(negedge clock_i);
        mode_i = 3'd1;
        solid_i = 12'h3C9;
        step(1);
        check("midframe_ramp", rgb, 12'h055);
        wait_frame();
        check("newframe_solid", rgb, 12'h3C9);

        // Whole-frame timing measurement.
        wait_frame();
        n = 0; hs_low = 0; vs_low = 0; first_hs = -1; first_vs = -1;
        do begin
            if (!hsync_o) begin hs_low++; if (first_hs < 0) first_hs = n; end
            if (!vsync_o) begin vs_low++; if (first_vs < 0) first_vs = n; end
            tick();
            n++;
        end while (!frame_o && n < 2 * FRAME);
        check("frame_period", n, FRAME);
        check("hsync_low_total", hs_low, VT * HSYNC);
        check("vsync_low_total", vs_low, VSYNC * HT);
        check("hsync_start", first_hs, HDISP + HFP);
        check("vsync_start", first_vs, (VDISP + VFP) * HT);

        // Randomized run, scoreboard only.
        @(negedge clock_i);
        mode_i = 3'd4;
        hold = 0;
        for (int c = 0; c < 9000; c++) begin
            @(negedge clock_i);
            if ($urandom_range(0, 399) == 0) mode_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) solid_i = RGBW'($urandom);
            if (hold > 0) begin
                hold--;
                if (hold == 0) enable_i = 1'b1;
            end else if ($urandom_range(0, 2999) == 0) begin
                enable_i = 1'b0;
                hold = $urandom_range(1, 20);
            end
        end
        @(negedge clock_i);
        enable_i = 1'b1;
        step(2);
        sb_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
